// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave: byte-addressed backing store behind independent read and
// write burst engines; out-of-range or illegal beats answer SLVERR.
module axi4_mem_slave #(
    parameter int          DATA_W    = 32,
    parameter int          ID_W      = 4,
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RD_LAT    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_W-1:0]     bid,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [ID_W-1:0]     rid
);
    localparam int         STRB_W      = DATA_W / 8;
    localparam int         SZ_MAX      = $clog2(STRB_W);
    localparam int         IDX_W       = $clog2(MEM_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic beat_err(input logic [31:0] a, input logic [2:0] sz,
                                      input logic [1:0] bt, input logic [7:0] ln);
        logic [31:0] off;
        off = a - BASE_ADDR;
        beat_err = (a < BASE_ADDR) || (off >= 32'(MEM_BYTES)) || (sz > 3'(SZ_MAX)) ||
                   (bt == 2'b11) ||
                   (bt == 2'b10 && !(ln inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bt, input logic [7:0] ln);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << sz;
        mask = ((({24'd0, ln}) + 32'd1) << sz) - 32'd1;
        case (bt)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a + step;
        endcase
    endfunction

    logic [7:0] mem_q [MEM_BYTES];

    r_state_e          r_state_q;
    logic [31:0]       r_addr_q;
    logic [7:0]        r_len_q;
    logic [2:0]        r_size_q;
    logic [1:0]        r_burst_q;
    logic [7:0]        r_beat_q;
    logic [3:0]        r_cnt_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic [ID_W-1:0]   rid_q;

    w_state_e          w_state_q;
    logic [31:0]       w_addr_q;
    logic [7:0]        w_len_q;
    logic [2:0]        w_size_q;
    logic [1:0]        w_burst_q;
    logic [7:0]        w_beat_q;
    logic              w_err_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;

    assign arready = (r_state_q == R_IDLE) && !reset;
    assign awready = (w_state_q == W_IDLE) && !reset;
    assign wready  = (w_state_q == W_DATA) && !reset;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;

    // The beat being loaded is the first one in R_WAIT, the successor in R_BEAT.
    logic [31:0]       r_next_addr;
    logic [31:0]       r_ld_addr;
    logic              r_ld_err;
    logic [IDX_W-1:0]  r_ld_idx;
    logic [DATA_W-1:0] r_ld_data;

    always_comb begin
        r_next_addr = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
        r_ld_addr   = (r_state_q == R_BEAT) ? r_next_addr : r_addr_q;
        r_ld_err    = beat_err(r_ld_addr, r_size_q, r_burst_q, r_len_q);
        r_ld_idx    = IDX_W'(r_ld_addr - BASE_ADDR) & ~IDX_W'(STRB_W - 1);
        r_ld_data   = '0;
        for (int b = 0; b < STRB_W; b++) begin
            r_ld_data[8*b +: 8] = mem_q[r_ld_idx | IDX_W'(b)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        r_addr_q  <= araddr;
                        r_len_q   <= arlen;
                        r_size_q  <= arsize;
                        r_burst_q <= arburst;
                        rid_q     <= arid;
                        r_beat_q  <= '0;
                        r_cnt_q   <= 4'(RD_LAT - 1);
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == 4'd0) begin
                        r_state_q <= R_BEAT;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= r_ld_err ? '0 : r_ld_data;
                        rresp_q   <= r_ld_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (r_len_q == 8'd0);
                    end else begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end
                end
                R_BEAT: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q <= r_next_addr;
                            r_beat_q <= r_beat_q + 8'd1;
                            rdata_q  <= r_ld_err ? '0 : r_ld_data;
                            rresp_q  <= r_ld_err ? RESP_SLVERR : RESP_OKAY;
                            rlast_q  <= (r_beat_q + 8'd1 == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    logic             w_hs;
    logic             w_beat_err;
    logic             w_last_beat;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_hs        = wvalid && wready;
        w_beat_err  = beat_err(w_addr_q, w_size_q, w_burst_q, w_len_q);
        w_last_beat = (w_beat_q == w_len_q);
        w_idx       = IDX_W'(w_addr_q - BASE_ADDR) & ~IDX_W'(STRB_W - 1);
    end

    // Burst length alone terminates the burst; a misplaced wlast only taints bresp.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awvalid) begin
                        w_addr_q  <= awaddr;
                        w_len_q   <= awlen;
                        w_size_q  <= awsize;
                        w_burst_q <= awburst;
                        bid_q     <= awid;
                        w_beat_q  <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        if (w_last_beat) begin
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (w_err_q || w_beat_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
                            w_beat_q <= w_beat_q + 8'd1;
                            w_err_q  <= w_err_q | w_beat_err | wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[w_idx | IDX_W'(b)] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Self-checking bench for axi4_mem_slave: a byte-array reference model feeds a
// scoreboard of expected R beats and B responses.
module tb_axi4_mem_slave;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    axi4_mem_slave #(.DATA_W(32), .ID_W(4), .MEM_BYTES(4096), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } exp_t;

    typedef struct {
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [3:0]        id;
        logic [3:0]        err_mask;
        logic [3:0][31:0]  ba;
        logic              tog;
    } rd_vec_t;

    exp_t    exp_q[$];
    logic [1:0] bq[$];
    rd_vec_t vecs[$];
    logic [7:0] model [4096];
    int nerr = 0;
    int nchk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] off;
        logic [11:0] o;
        off = a - BASE;
        o   = {off[11:2], 2'b00};
        return {model[o + 12'd3], model[o + 12'd2], model[o + 12'd1], model[o]};
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [31:0] d0, input logic [31:0] dstep, input logic [3:0] strb,
                            input int bad_last);
        int cnt;
        logic [31:0] a, off, d;
        logic [1:0] eb;
        bq.push_back((bad_last >= 0) ? 2'b10 : 2'b00);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b01;
        cnt = 0;
        while (!awready && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            d = d0 + dstep * 32'(i);
            wvalid = 1'b1; wdata = d; wstrb = strb;
            wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            cnt = 0;
            while (!wready && cnt < 40) begin @(posedge clk); #1; cnt++; end
            check("wready", wready, 1);
            a   = addr + 32'(4 * i);
            off = a - BASE;
            if (a >= BASE && off < 32'd4096) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[off[11:0] + 12'(b)] = d[8*b +: 8];
                end
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_end", wready, 0);
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("bvalid", bvalid, 1);
        eb = bq.pop_front();
        check("bresp", bresp, eb);
        check("bid", bid, id);
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("awready_after_b", awready, 1);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int cnt;
        arvalid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        cnt = 0;
        while (!arready && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic rd_collect(input int n, input logic tog);
        int   cnt, beat, guard;
        logic hold, nxt;
        exp_t e;
        cnt = 0;
        while (!rvalid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("rd_first_valid", rvalid, 1);
        check("rd_latency", cnt, RD_LAT);
        beat = 0; guard = 0;
        while (beat < n && guard < 2000) begin
            rready = tog ? guard[0] : 1'b1;
            hold = 1'b0; nxt = 1'b0;
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL rd_sb_empty: got beat %0d with no expectation", beat);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rdata, e.data);
                    check("rd_resp", rresp, e.resp);
                    check("rd_last", rlast, e.last);
                    check("rd_id", rid, e.id);
                    nxt = !e.last;
                end
                beat++;
            end else if (rvalid) begin
                hold = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
            if (nxt) check("rd_next_beat", rvalid, 1);
            if (hold && exp_q.size() > 0) begin
                check("rd_hold_valid", rvalid, 1);
                check("rd_hold_data", rdata, exp_q[0].data);
                check("rd_hold_last", rlast, exp_q[0].last);
            end
        end
        rready = 1'b0;
        check("rd_beats", beat, n);
        check("rd_idle_valid", rvalid, 0);
        check("arready_after_r", arready, 1);
    endtask

    task automatic add_vec(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [3:0] em,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic tog);
        rd_vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id; v.err_mask = em;
        v.ba[0] = a0; v.ba[1] = a1; v.ba[2] = a2; v.ba[3] = a3; v.tog = tog;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic err, input logic last, input logic [3:0] id);
        exp_t e;
        e.data = err ? 32'h0 : mword(a);
        e.resp = err ? 2'b10 : 2'b00;
        e.last = last;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        #1;
        check("post_rst_arready", arready, 1);
        check("post_rst_awready", awready, 1);
        @(posedge clk); #1;

        do_write(32'h8000_0000, 8'd3, 4'd1, 32'h11, 32'h11, 4'hF, -1);
        do_write(32'h8000_0010, 8'd3, 4'd2, 32'hA0A0_0001, 32'h1, 4'hF, -1);
        do_write(32'h8000_0020, 8'd0, 4'd3, 32'hDEAD_BEEF, 32'h0, 4'hF, -1);
        do_write(32'h8000_0FFC, 8'd0, 4'd4, 32'h1234_5678, 32'h0, 4'hF, -1);
        do_write(32'h8000_0030, 8'd0, 4'd5, 32'h0, 32'h0, 4'hF, -1);
        do_write(32'h8000_0030, 8'd0, 4'd6, 32'hAABB_CCDD, 32'h0, 4'b0101, -1);
        do_write(32'h8000_0100, 8'd3, 4'd7, 32'h5555_0000, 32'h1, 4'hF, 1);

        add_vec(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd5,  4'b0000, 32'h8000_0010, 0, 0, 0, 1'b0);
        add_vec(32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd1,  4'b0000, 32'h8000_0000, 32'h8000_0004,
                32'h8000_0008, 32'h8000_000C, 1'b1);
        add_vec(32'h8000_0018, 8'd3, 3'd2, 2'b10, 4'd2,  4'b0000, 32'h8000_0018, 32'h8000_001C,
                32'h8000_0010, 32'h8000_0014, 1'b0);
        add_vec(32'h8000_0030, 8'd0, 3'd2, 2'b01, 4'd6,  4'b0000, 32'h8000_0030, 0, 0, 0, 1'b0);
        add_vec(32'h8000_1000, 8'd0, 3'd2, 2'b01, 4'd3,  4'b0001, 0, 0, 0, 0, 1'b0);
        add_vec(32'h8000_0020, 8'd1, 3'd2, 2'b00, 4'd4,  4'b0000, 32'h8000_0020, 32'h8000_0020, 0, 0, 1'b1);
        add_vec(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd7,  4'b0001, 0, 0, 0, 0, 1'b0);
        add_vec(32'h8000_0000, 8'd0, 3'd2, 2'b11, 4'd8,  4'b0001, 0, 0, 0, 0, 1'b0);
        add_vec(32'h8000_0010, 8'd2, 3'd2, 2'b10, 4'd9,  4'b0111, 0, 0, 0, 0, 1'b0);
        add_vec(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd10, 4'b0001, 0, 0, 0, 0, 1'b0);
        add_vec(32'h8000_0FFC, 8'd1, 3'd2, 2'b01, 4'd11, 4'b0010, 32'h8000_0FFC, 0, 0, 0, 1'b0);

        foreach (vecs[k]) begin
            for (int i = 0; i <= int'(vecs[k].len); i++) begin
                push_exp(vecs[k].ba[i], vecs[k].err_mask[i], i == int'(vecs[k].len), vecs[k].id);
            end
            ar_send(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].id);
            rd_collect(int'(vecs[k].len) + 1, vecs[k].tog);
        end

        do_write(32'h8000_0400, 8'd255, 4'd12, 32'h0100_0000, 32'h0000_0101, 4'hF, -1);
        for (int i = 0; i < 256; i++) push_exp(32'h8000_0400 + 32'(4 * i), 1'b0, i == 255, 4'd12);
        ar_send(32'h8000_0400, 8'd255, 3'd2, 2'b01, 4'd12);
        rd_collect(256, 1'b0);

        ar_send(32'h8000_0000, 8'd7, 3'd2, 2'b01, 4'd13);
        begin
            int cnt;
            cnt = 0;
            while (!rvalid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        end
        check("rst_burst_valid", rvalid, 1);
        rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_burst_data", rdata, mword(BASE + 32'(4 * k)));
            @(posedge clk); #1;
        end
        check("rst_burst_beat2", rdata, mword(BASE + 32'd8));
        rready = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("midrst_rvalid", rvalid, 0);
        check("midrst_arready", arready, 0);
        check("midrst_rlast", rlast, 0);
        check("midrst_rdata", rdata, 0);
        reset = 1'b0;
        #1;
        check("midrst_arready_after", arready, 1);
        check("midrst_awready_after", awready, 1);
        @(posedge clk); #1;
        push_exp(32'h8000_0008, 1'b0, 1'b0, 4'd14);
        push_exp(32'h8000_000C, 1'b0, 1'b1, 4'd14);
        ar_send(32'h8000_0008, 8'd1, 3'd2, 2'b01, 4'd14);
        rd_collect(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/axi4_mem_slave.md
AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- DATA_W, 32, data bus width in bits; legal values 32 and 64.
- ID_W, 4, AXI ID width.
- MEM_BYTES, 4096, backing store size in bytes; power of two.
- BASE_ADDR, 32'h8000_0000, address of byte 0.
- RD_LAT, 2, cycles from AR handshake to first rvalid; legal range 1..15.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- awvalid/awready, in/out, 1/1, write address handshake.
- awaddr, in, 32; awid, in, ID_W; awlen, in, 8; awsize, in, 3; awburst, in, 2.
- wvalid/wready, in/out, 1/1; wdata, in, DATA_W; wstrb, in, DATA_W/8; wlast, in, 1.
- bvalid/bready, out/in, 1/1; bresp, out, 2; bid, out, ID_W.
- arvalid/arready, in/out, 1/1; araddr, in, 32; arid, in, ID_W; arlen, in, 8; arsize, in, 3; arburst, in, 2.
- rvalid/rready, out/in, 1/1; rdata, out, DATA_W; rresp, out, 2; rlast, out, 1; rid, out, ID_W.

Function
REQ-004 The block SHALL use an internal byte-addressable array of MEM_BYTES bytes. Index = (addr - BASE_ADDR) aligned down to DATA_W/8. Memory contents are not reset.
REQ-005 The read and write channels SHALL be independent FSMs and SHALL be able to run concurrently.
REQ-006 The read FSM SHALL have states R_IDLE, R_WAIT and R_BEAT. arready is 1 only in R_IDLE with reset low.
REQ-007 On an AR handshake the block SHALL latch araddr, arid, arlen, arsize and arburst, load the latency counter with RD_LAT-1, and move to R_WAIT.
REQ-008 R_WAIT SHALL decrement the counter and enter R_BEAT when it is 0. The first rvalid therefore occurs exactly RD_LAT cycles after the AR handshake edge.
REQ-009 In R_BEAT, rvalid, rdata, rresp, rlast and rid SHALL hold stable until rready.
- On each R handshake that is not the last beat, the next beat SHALL be presented in the following cycle.
- rlast is 1 only on beat index arlen.
- After the last handshake the FSM returns to R_IDLE; the next arready occurs in the following cycle.
REQ-010 The beat address update SHALL depend on burst type:
- FIXED (00): address unchanged.
- INCR (01): address + 2^size.
- WRAP (10): address + 2^size, wrapping within an aligned block of (len+1)*2^size bytes; legal only for len+1 in {2,4,8,16}.
REQ-011 A beat SHALL return rresp=SLVERR (2'b10) and rdata=0 when any of these holds:
- its address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES);
- size > log2(DATA_W/8);
- burst = 11;
- WRAP with an illegal length.
Otherwise rresp=OKAY (2'b00).
REQ-012 The write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1). The AW handshake latches the AW fields and enters W_DATA.
REQ-013 Each W handshake SHALL write the bytes enabled by wstrb at the current beat address, using the REQ-010 address update. Out-of-range or illegal beats write nothing.
REQ-014 The write burst SHALL end on the handshake of beat index awlen, regardless of wlast, and move to W_RESP.
REQ-015 bresp SHALL be SLVERR if any beat was erroneous or wlast != (beat index == awlen) on any beat; otherwise OKAY. bid SHALL equal the latched awid.
REQ-016 bvalid, bresp and bid SHALL hold until bready. The FSM then returns to W_IDLE in the next cycle.
REQ-017 A memory write SHALL take effect at the W handshake edge. A read beat loaded on that same edge SHALL return the pre-write data; a read beat loaded on any later edge SHALL return the new data.
REQ-018 Per-beat read and write counters SHALL be 8 bits wide and SHALL support bursts of 256 beats (len=255) without wrap-around error.

Reset
REQ-019 While reset is high at a clock edge, both FSMs SHALL enter their IDLE states. Resulting values: arready=awready=wready=0 while reset is high; rvalid=bvalid=rlast=0; rresp=bresp=0; rid=bid=0; rdata=0.
REQ-020 Reset asserted mid-burst SHALL abandon the transaction with no response issued. Writes already handshaken stay in memory.
REQ-021 In the first cycle after reset deasserts, arready=awready=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- RD_LAT=2: AR to 0x8000_0010, len=0, size=2, INCR, arid=5 -> rvalid exactly 2 cycles after handshake, rlast=1, rid=5, rresp=OKAY.
- INCR write of 4 beats at 0x8000_0000 with data 0x11..0x44 and full strobes, then INCR read of the same 4 beats with rready toggling every cycle -> data matches, rvalid/rdata held while rready=0, rlast on beat 3, bresp=OKAY.
- WRAP read, len=3, size=2, start 0x8000_0018 -> beat addresses 0x18, 0x1C, 0x10, 0x14.
- Write with wstrb=4'b0101 and data 0xAABBCCDD over 0x00000000 -> readback 0x00BB00DD.
- Read at BASE_ADDR+MEM_BYTES -> rresp=SLVERR, rdata=0. Write with wlast asserted on beat 1 of len=3 -> 4 beats accepted, bresp=SLVERR.
- Reset asserted during beat 2 of an 8-beat read -> rvalid=0 on the next cycle, arready=1 one cycle after reset deasserts, and a new read completes normally.
